// File: rtl/cache_types.sv
// Shared cache-side types: line/beat geometry and the adaptor state encoding.
// Reused by the cache controllers and the memory-side line adaptor.
package cache_types;

   localparam int LINE_W  = 256;
   localparam int BURST_W = 64;
   localparam int BEATS   = LINE_W / BURST_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one cache-line read/write-back into a four-beat memory burst and
// returns a one-cycle completion pulse to the cache once the burst finishes.
module cacheline_adaptor #(
   parameter int LINE_W  = cache_types::LINE_W,
   parameter int BURST_W = cache_types::BURST_W
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                pmem_read,
   input  logic                pmem_write,
   input  logic [31:0]         pmem_address,
   input  logic [LINE_W-1:0]   pmem_wdata,
   output logic [LINE_W-1:0]   pmem_rdata,
   output logic                pmem_resp,
   output logic [31:0]         address_o,
   output logic                read_o,
   output logic                write_o,
   output logic [BURST_W-1:0]  burst_o,
   input  logic [BURST_W-1:0]  burst_i,
   input  logic                resp_i,
   output logic [1:0]          fsm_state
);

   import cache_types::*;

   localparam logic [1:0] LAST_BEAT = 2'(LINE_W / BURST_W - 1);

   state_t             state;
   logic [1:0]         beat;
   logic [31:0]        addr_q;
   logic [LINE_W-1:0]  wline_q;
   logic [LINE_W-1:0]  rline_q;

   // Read data is assembled in place so pmem_rdata stays valid until the
   // next read overwrites beat 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         beat    <= 2'd0;
         addr_q  <= 32'd0;
         wline_q <= '0;
         rline_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               beat <= 2'd0;
               if (pmem_write) begin
                  addr_q  <= {pmem_address[31:5], 5'b0};
                  wline_q <= pmem_wdata;
                  state   <= WR;
               end else if (pmem_read) begin
                  addr_q <= {pmem_address[31:5], 5'b0};
                  state  <= RD;
               end
            end
            RD: begin
               if (resp_i) begin
                  rline_q[int'(beat)*BURST_W +: BURST_W] <= burst_i;
                  beat <= beat + 2'd1;
                  if (beat == LAST_BEAT) state <= DONE;
               end
            end
            WR: begin
               if (resp_i) begin
                  beat <= beat + 2'd1;
                  if (beat == LAST_BEAT) state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Memory-side strobes decode only the registered state.
   always_comb begin
      burst_o = '0;
      if (state == WR) burst_o = wline_q[int'(beat)*BURST_W +: BURST_W];
   end

   assign read_o     = (state == RD);
   assign write_o    = (state == WR);
   assign pmem_resp  = (state == DONE);
   assign address_o  = addr_q;
   assign pmem_rdata = rline_q;
   assign fsm_state  = state;

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameters: LINE_W default 256, cache line width in bits; BURST_W default 64, memory beat width in bits; BEATS fixed LINE_W/BURST_W = 4.
REQ-002 SHALL use one clock and an asynchronous, active-low reset:
  clk  in  1  rising-edge clock
  reset_n  in  1  asynchronous active-low reset
  pmem_read  in  1  cache-side line read request, held until pmem_resp
  pmem_write  in  1  cache-side line write-back request, held until pmem_resp
  pmem_address  in  32  line address from cache
  pmem_wdata  in  LINE_W  line to write back
  pmem_rdata  out  LINE_W  line returned on read
  pmem_resp  out  1  one-cycle completion pulse to cache
  address_o  out  32  memory burst address, low 5 bits zero
  read_o  out  1  memory burst read request
  write_o  out  1  memory burst write request
  burst_o  out  BURST_W  write beat data
  burst_i  in  BURST_W  read beat data
  resp_i  in  1  memory beat strobe, one per beat

Function
REQ-003 SHALL implement states IDLE, RD, WR, DONE.
REQ-004 In IDLE: pmem_write high -> latch pmem_address (bits 4:0 forced 0) and pmem_wdata, go WR; else pmem_read high -> latch address, go RD; else stay.
REQ-005 Simultaneous pmem_read and pmem_write in IDLE SHALL be serviced as a write.
REQ-006 read_o SHALL be high exactly while in RD; write_o exactly while in WR; both registered-state decoded, no combinational path from pmem_* inputs.
REQ-007 address_o SHALL hold the latched aligned address throughout RD/WR and DONE.
REQ-008 2-bit beat counter SHALL reset to 0 on entry to RD/WR and increment on each cycle with resp_i high in RD/WR.
REQ-009 In RD, each resp_i cycle SHALL capture burst_i into line bits [64*k+63:64*k], k = beat counter (beat 0 = least significant).
REQ-010 In WR, burst_o SHALL present latched line bits [64*k+63:64*k]; memory consumes the beat on each resp_i cycle.
REQ-011 resp_i with counter = 3 SHALL transition to DONE; counter wraps to 0.
REQ-012 Gaps (resp_i low) between beats SHALL stall the counter without losing data.
REQ-013 In DONE: pmem_resp = 1 for exactly one cycle, pmem_rdata valid; next state IDLE unconditionally.
REQ-014 pmem_rdata SHALL remain stable from DONE until the next read captures beat 0.
REQ-015 A request still asserted in the cycle after DONE SHALL be treated as a new request (cache must drop it on pmem_resp).
REQ-016 resp_i in IDLE or DONE SHALL be ignored.
REQ-017 Latency: request seen at cycle N -> read_o/write_o high at N+1; fourth resp_i at cycle M -> pmem_resp high at M+1.
REQ-018 burst_o SHALL be 0 outside WR.

Reset
REQ-019 reset_n low SHALL asynchronously force IDLE, counter 0, pmem_resp 0, read_o 0, write_o 0, address_o 0, burst_o 0, pmem_rdata 0, latched line 0.
REQ-020 Reset mid-burst SHALL abandon the transfer; no pmem_resp issued for it; operation resumes from IDLE on the first edge after deassertion.

Structure
REQ-021 LINE_W, BURST_W, BEATS and the state enum SHALL live in the shared cache_types package, reused by the cache controllers.
REQ-022 Single module; no sub-module (counter and line buffer inline).

Verification
REQ-023 Read: pmem_read, addr 0x0000_1234; resp_i 4 consecutive cycles with burst_i 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o 0x0000_1220, pmem_rdata = {0x44..,0x33..,0x22..,0x11..}, one-cycle pmem_resp.
REQ-024 Write: pmem_write, addr 0x8000_0040, wdata {D3,D2,D1,D0} -> write_o high, burst_o D0..D3 on successive resp_i, write_o drops after fourth, pmem_resp one cycle.
REQ-025 Stalled read: resp_i pattern 1,0,0,1,1,0,1 -> correct line assembled, pmem_resp one cycle after last beat.
REQ-026 Both pmem_read and pmem_write high in IDLE -> write_o asserted, read_o never asserted.
REQ-027 reset_n low after 2 beats of a read -> read_o 0 immediately, no pmem_resp; following read completes with correct data.
REQ-028 Back-to-back: write-back then read held after pmem_resp -> second request starts next IDLE cycle, spurious resp_i in IDLE ignored.
